// File: rtl/nregister_pipe.sv
// nregister_pipe: elastic chain of DEPTH valid/ready register stages with flush and occupancy count
module nregister_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_bits,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_bits,
    input  logic             io_flush,
    output logic [CW-1:0]    io_count
);
    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;
    // A stage is ready if it or any stage downstream of it has a hole, or the consumer takes a word
    always_comb begin
        logic w_acc;
        w_acc = io_out_ready;
        w_rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_acc    = w_acc || !r_v[i];
            w_rdy[i] = w_acc;
        end
    end
    assign io_in_ready  = w_rdy[0] && !io_flush && !reset;
    assign w_in_xfer    = io_in_valid && io_in_ready;
    assign w_out_xfer   = r_v[DEPTH-1] && io_out_ready;
    assign io_out_valid = r_v[DEPTH-1];
    assign io_out_bits  = r_d[DEPTH-1];
    assign io_count     = r_count;
    for (genvar g = 0; g < DEPTH; g++) begin : g_src
        if (g == 0) begin : g_head
            assign w_src_v[g] = w_in_xfer;
            assign w_src_d[g] = io_in_bits;
        end else begin : g_link
            assign w_src_v[g] = r_v[g-1];
            assign w_src_d[g] = r_d[g-1];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v     <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_d[i] <= RESET_VALUE;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) r_v[i] <= w_src_v[i];
                if (w_rdy[i] && w_src_v[i]) r_d[i] <= w_src_d[i];
            end
            if (io_flush) begin
                r_v     <= '0;
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
            end
        end
    end
endmodule

// File: tb/tb_nregister_pipe.sv
// tb_nregister_pipe: directed and randomized checks of a DEPTH=3 and a DEPTH=1 chain against a queue model
module tb_nregister_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       a_iv, a_ir, a_ov, a_or, a_fl;
    logic [7:0] a_ib, a_ob;
    logic [1:0] a_cnt;
    logic       b_iv, b_ir, b_ov, b_or, b_fl;
    logic [7:0] b_ib, b_ob;
    logic       b_cnt;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] q [$];
    always #5 clk = ~clk;
    nregister_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hC3)) u_a (
        .clk(clk), .reset(rst),
        .io_in_valid(a_iv), .io_in_ready(a_ir), .io_in_bits(a_ib),
        .io_out_valid(a_ov), .io_out_ready(a_or), .io_out_bits(a_ob),
        .io_flush(a_fl), .io_count(a_cnt)
    );
    nregister_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00)) u_b (
        .clk(clk), .reset(rst),
        .io_in_valid(b_iv), .io_in_ready(b_ir), .io_in_bits(b_ib),
        .io_out_valid(b_ov), .io_out_ready(b_or), .io_out_bits(b_ob),
        .io_flush(b_fl), .io_count(b_cnt)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic set_a(input logic iv, input logic [7:0] ib, input logic ordy, input logic fl);
        a_iv = iv; a_ib = ib; a_or = ordy; a_fl = fl;
        #1;
    endtask
    task automatic set_b(input logic iv, input logic [7:0] ib, input logic ordy);
        b_iv = iv; b_ib = ib; b_or = ordy;
        #1;
    endtask
    initial begin
        b_fl = 1'b0;
        set_b(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        set_a(1'b1, 8'h00, 1'b1, 1'b0);
        chk("rst_in_ready", a_ir, 0);
        tick;
        tick;
        rst = 1'b0;
        set_a(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_bits", a_ob, 8'hC3);
        chk("rst_count", a_cnt, 0);
        chk("post_rst_in_ready", a_ir, 1);
        // streaming with consumer always ready
        set_a(1'b1, 8'h11, 1'b1, 1'b0);
        chk("s_ready0", a_ir, 1);
        tick;
        set_a(1'b1, 8'h22, 1'b1, 1'b0);
        chk("s_ov1", a_ov, 0);
        chk("s_cnt1", a_cnt, 1);
        tick;
        set_a(1'b1, 8'h33, 1'b1, 1'b0);
        chk("s_ov2", a_ov, 0);
        chk("s_cnt2", a_cnt, 2);
        tick;
        set_a(1'b0, 8'h00, 1'b1, 1'b0);
        chk("s_ov3", a_ov, 1);
        chk("s_ob3", a_ob, 8'h11);
        chk("s_cnt3", a_cnt, 3);
        tick;
        chk("s_ob4", a_ob, 8'h22);
        chk("s_cnt4", a_cnt, 2);
        tick;
        chk("s_ob5", a_ob, 8'h33);
        chk("s_cnt5", a_cnt, 1);
        tick;
        chk("s_ov6", a_ov, 0);
        chk("s_cnt6", a_cnt, 0);
        // fill under stall, then simultaneous in/out on a full chain
        set_a(1'b1, 8'hA1, 1'b0, 1'b0);
        chk("f_ready1", a_ir, 1);
        tick;
        set_a(1'b1, 8'hA2, 1'b0, 1'b0);
        chk("f_ready2", a_ir, 1);
        chk("f_cnt1", a_cnt, 1);
        tick;
        set_a(1'b1, 8'hA3, 1'b0, 1'b0);
        chk("f_ready3", a_ir, 1);
        chk("f_cnt2", a_cnt, 2);
        tick;
        set_a(1'b1, 8'hA4, 1'b0, 1'b0);
        chk("f_full_ready", a_ir, 0);
        chk("f_cnt3", a_cnt, 3);
        chk("f_head", a_ob, 8'hA1);
        tick;
        chk("f_hold_ready", a_ir, 0);
        chk("f_hold_cnt", a_cnt, 3);
        set_a(1'b1, 8'hA4, 1'b1, 1'b0);
        chk("f_pass_ready", a_ir, 1);
        chk("f_pass_ov", a_ov, 1);
        chk("f_pass_ob", a_ob, 8'hA1);
        tick;
        set_a(1'b0, 8'h00, 1'b1, 1'b0);
        chk("f_pass_cnt", a_cnt, 3);
        chk("f_ob_a2", a_ob, 8'hA2);
        tick;
        chk("f_ob_a3", a_ob, 8'hA3);
        chk("f_cnt_d2", a_cnt, 2);
        tick;
        chk("f_ob_a4", a_ob, 8'hA4);
        chk("f_cnt_d1", a_cnt, 1);
        tick;
        chk("f_empty", a_ov, 0);
        chk("f_cnt_d0", a_cnt, 0);
        // a lone word compacts to the output under stall
        set_a(1'b1, 8'h5C, 1'b0, 1'b0);
        tick;
        set_a(1'b0, 8'h00, 1'b0, 1'b0);
        chk("c_ov1", a_ov, 0);
        chk("c_cnt1", a_cnt, 1);
        tick;
        chk("c_ov2", a_ov, 0);
        tick;
        chk("c_ov3", a_ov, 1);
        chk("c_ob3", a_ob, 8'h5C);
        chk("c_cnt3", a_cnt, 1);
        tick;
        chk("c_hold_ov", a_ov, 1);
        chk("c_hold_ob", a_ob, 8'h5C);
        set_a(1'b0, 8'h00, 1'b1, 1'b0);
        chk("c_take_ob", a_ob, 8'h5C);
        tick;
        chk("c_done_ov", a_ov, 0);
        chk("c_done_cnt", a_cnt, 0);
        // flush discards held words and blocks the offered one
        set_a(1'b1, 8'h01, 1'b0, 1'b0);
        tick;
        set_a(1'b1, 8'h02, 1'b0, 1'b0);
        tick;
        set_a(1'b1, 8'h77, 1'b0, 1'b1);
        chk("fl_ready", a_ir, 0);
        chk("fl_cnt_before", a_cnt, 2);
        tick;
        set_a(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fl_cnt", a_cnt, 0);
        chk("fl_ov", a_ov, 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("fl_no_emerge", a_ov, 0);
        end
        // reset mid-stream
        set_a(1'b1, 8'hB1, 1'b0, 1'b0);
        tick;
        set_a(1'b1, 8'hB2, 1'b0, 1'b0);
        tick;
        set_a(1'b1, 8'hB3, 1'b0, 1'b0);
        tick;
        rst = 1'b1;
        set_a(1'b1, 8'hDD, 1'b1, 1'b0);
        chk("mr_cnt_before", a_cnt, 3);
        chk("mr_ready", a_ir, 0);
        tick;
        chk("mr_ov", a_ov, 0);
        chk("mr_ob", a_ob, 8'hC3);
        chk("mr_cnt", a_cnt, 0);
        chk("mr_ready_held", a_ir, 0);
        rst = 1'b0;
        set_a(1'b0, 8'h00, 1'b1, 1'b0);
        chk("mr_ready_after", a_ir, 1);
        // randomized traffic on the DEPTH=3 chain
        q.delete();
        for (int c = 0; c < 400; c++) begin
            logic iv, ordy, exp_ir;
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            set_a(iv, 8'($urandom), ordy, 1'b0);
            exp_ir = (q.size() < 3) || ordy;
            chk("ra_ready", a_ir, exp_ir);
            chk("ra_cnt", a_cnt, q.size());
            if (a_ov && ordy) begin
                if (q.size() == 0) chk("ra_spurious", a_ov, 0);
                else begin
                    chk("ra_bits", a_ob, q[0]);
                    void'(q.pop_front());
                end
            end
            if (iv && exp_ir) q.push_back(a_ib);
            tick;
        end
        set_a(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            if (a_ov) begin
                chk("ra_drain_bits", a_ob, q[0]);
                void'(q.pop_front());
            end
            tick;
        end
        chk("ra_drained", q.size(), 0);
        chk("ra_final_cnt", a_cnt, 0);
        // randomized traffic on the DEPTH=1 slice
        q.delete();
        for (int c = 0; c < 1000; c++) begin
            logic iv, ordy, exp_ir;
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            set_b(iv, 8'($urandom), ordy);
            exp_ir = (q.size() == 0) || ordy;
            chk("rb_ready", b_ir, exp_ir);
            chk("rb_cnt", b_cnt, q.size());
            chk("rb_ov", b_ov, q.size() == 1);
            if (b_ov && ordy && q.size() == 1) begin
                chk("rb_bits", b_ob, q[0]);
                void'(q.pop_front());
            end
            if (iv && exp_ir) q.push_back(b_ib);
            tick;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
